// File: rtl/interrupt_sequencer_multi.sv
// Interrupt / BRK / RTI sequencer: arbitrates prioritised hardware sources, pushes
// PC and status onto page 1, fetches the vector, and unwinds the frame on RTI.
module interrupt_sequencer_multi #(
    parameter int                 NUM_SRC   = 4,
    parameter logic [NUM_SRC-1:0] NMI_MASK  = 4'b0001,
    parameter logic [NUM_SRC-1:0] EDGE_MASK = 4'b0001,
    parameter logic [15:0]        VEC_BASE  = 16'hFFF0,
    parameter logic [15:0]        BRK_VEC   = 16'hFFFE,
    parameter int                 MAX_NEST  = 3,
    localparam int                SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int                NEST_W    = (MAX_NEST > 0) ? $clog2(MAX_NEST + 1) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               halt,
    input  logic               start,
    input  logic               is_brk,
    input  logic               is_rti,
    input  logic [NUM_SRC-1:0] src_n,
    input  logic [15:0]        pc_in,
    input  logic [7:0]         status_in,
    input  logic [7:0]         sp_in,
    output logic [15:0]        mem_addr,
    input  logic [7:0]         mem_rdata,
    output logic [7:0]         mem_wdata,
    output logic               mem_we,
    output logic               busy,
    output logic               done,
    output logic [15:0]        pc_out,
    output logic [7:0]         status_out,
    output logic [7:0]         sp_out,
    output logic [NUM_SRC-1:0] src_ack,
    output logic [SRC_W-1:0]   active_src,
    output logic [NEST_W-1:0]  nest_depth
);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] FETCH_HI = 4'd1;
    localparam logic [3:0] PUSH_PCH = 4'd2;
    localparam logic [3:0] PUSH_PCL = 4'd3;
    localparam logic [3:0] PUSH_P   = 4'd4;
    localparam logic [3:0] POP_1    = 4'd5;
    localparam logic [3:0] POP_2    = 4'd6;
    localparam logic [3:0] POP_3    = 4'd7;
    localparam logic [3:0] POP_4    = 4'd8;
    localparam logic [3:0] FIN      = 4'd9;

    logic [3:0]         state;
    logic [NUM_SRC-1:0] src_hist;
    logic [NUM_SRC-1:0] pend_edge;
    logic [NUM_SRC-1:0] pend;
    logic [NUM_SRC-1:0] nmi_pend;
    logic [NUM_SRC-1:0] irq_pend;
    logic [NUM_SRC-1:0] take;
    logic               hw_ok;
    logic               sel_rti;
    logic               sel_brk;
    logic               sel_hw;
    logic [SRC_W-1:0]   sel_idx;
    logic [15:0]        sel_vec;
    logic               accept;

    logic               rd_fresh;
    logic [7:0]         rd_stash;
    logic [7:0]         rd;
    logic [15:0]        vec_addr;
    logic [7:0]         vec_lo;
    logic [7:0]         push_st;

    function automatic logic [SRC_W-1:0] lowest(input logic [NUM_SRC-1:0] v);
        lowest = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (v[i]) lowest = SRC_W'(i);
        end
    endfunction

    function automatic logic [7:0] push_status(input logic brk, input logic [7:0] p);
        push_status = brk ? (p | 8'h30) : ((p | 8'h20) & 8'hEF);
    endfunction

    assign busy   = (state != IDLE);
    assign accept = (state == IDLE) && start && !halt;

    always_comb begin
        pend     = (pend_edge & EDGE_MASK) | (~src_n & ~EDGE_MASK);
        nmi_pend = pend & NMI_MASK;
        irq_pend = pend & ~NMI_MASK;
        hw_ok    = (nest_depth != NEST_W'(MAX_NEST));
        sel_rti  = 1'b0;
        sel_brk  = 1'b0;
        sel_hw   = 1'b0;
        sel_idx  = '0;
        take     = '0;
        if (is_rti) begin
            sel_rti = 1'b1;
        end else if (hw_ok && (|nmi_pend)) begin
            sel_hw  = 1'b1;
            sel_idx = lowest(nmi_pend);
        end else if (is_brk) begin
            sel_brk = 1'b1;
        end else if (hw_ok && !status_in[2] && (|irq_pend)) begin
            sel_hw  = 1'b1;
            sel_idx = lowest(irq_pend);
        end
        sel_vec = sel_brk ? BRK_VEC : (VEC_BASE + (16'(sel_idx) << 1));
        if (accept && sel_hw) take[sel_idx] = 1'b1;
    end

    // Edge capture keeps running while halted; a fresh fall beats the clear on take.
    always_ff @(posedge clk) begin
        if (rst) begin
            src_hist  <= '1;
            pend_edge <= '0;
        end else begin
            src_hist  <= src_n;
            pend_edge <= ((src_hist & ~src_n) | (pend_edge & ~take)) & EDGE_MASK;
        end
    end

    // Read data is only valid the cycle after the address; hold it across a halt.
    always_ff @(posedge clk) begin
        if (rst) rd_fresh <= 1'b1;
        else     rd_fresh <= !halt;
    end

    always_ff @(posedge clk) begin
        if (halt && rd_fresh) rd_stash <= mem_rdata;
    end

    assign rd = rd_fresh ? mem_rdata : rd_stash;

    always_ff @(posedge clk) begin
        if (!halt) begin
            if (accept) begin
                vec_addr <= sel_vec;
                push_st  <= push_status(sel_brk, status_in);
            end
            if (state == PUSH_PCH) vec_lo <= rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_we     <= 1'b0;
            done       <= 1'b0;
            pc_out     <= '0;
            status_out <= '0;
            sp_out     <= '0;
            src_ack    <= '0;
            active_src <= '0;
            nest_depth <= '0;
        end else if (!halt) begin
            done    <= 1'b0;
            src_ack <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pc_out     <= pc_in;
                        status_out <= status_in;
                        sp_out     <= sp_in;
                        if (sel_rti) begin
                            mem_addr <= {8'h01, sp_in + 8'd1};
                            if (nest_depth != '0) nest_depth <= nest_depth - NEST_W'(1);
                            state <= POP_1;
                        end else if (sel_hw || sel_brk) begin
                            mem_addr   <= sel_vec;
                            status_out <= status_in | 8'h04;
                            state      <= FETCH_HI;
                            if (sel_hw) begin
                                src_ack    <= take;
                                active_src <= sel_idx;
                                if (hw_ok) nest_depth <= nest_depth + NEST_W'(1);
                            end
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                FETCH_HI: begin
                    mem_addr <= vec_addr + 16'd1;
                    state    <= PUSH_PCH;
                end
                PUSH_PCH: begin
                    mem_addr  <= {8'h01, sp_out};
                    mem_wdata <= pc_out[15:8];
                    mem_we    <= 1'b1;
                    state     <= PUSH_PCL;
                end
                PUSH_PCL: begin
                    pc_out    <= {rd, vec_lo};
                    mem_addr  <= {8'h01, sp_out - 8'd1};
                    mem_wdata <= pc_out[7:0];
                    state     <= PUSH_P;
                end
                PUSH_P: begin
                    mem_addr  <= {8'h01, sp_out - 8'd2};
                    mem_wdata <= push_st;
                    sp_out    <= sp_out - 8'd3;
                    done      <= 1'b1;
                    state     <= FIN;
                end
                POP_1: begin
                    mem_addr <= {8'h01, sp_out + 8'd2};
                    state    <= POP_2;
                end
                POP_2: begin
                    status_out <= rd & 8'hCF;
                    mem_addr   <= {8'h01, sp_out + 8'd3};
                    state      <= POP_3;
                end
                POP_3: begin
                    pc_out[7:0] <= rd;
                    state       <= POP_4;
                end
                POP_4: begin
                    pc_out[15:8] <= rd;
                    sp_out       <= sp_out + 8'd3;
                    done         <= 1'b1;
                    state        <= FIN;
                end
                FIN: begin
                    mem_we <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    mem_we <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer_multi.sv
// Randomised bench for interrupt_sequencer_multi against a transaction-level model.
module tb_interrupt_sequencer_multi;

    localparam logic [3:0]  NMI_M = 4'b0001;
    localparam logic [3:0]  EDGE_M = 4'b0001;
    localparam logic [15:0] VBASE = 16'hFFF0;
    localparam logic [15:0] BVEC = 16'hFFFE;
    localparam int          MAXN = 3;

    logic        clk = 1'b0;
    logic        rst, halt, start, is_brk, is_rti;
    logic [3:0]  src_n;
    logic [15:0] pc_in;
    logic [7:0]  status_in, sp_in;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata, mem_wdata;
    logic        mem_we, busy, done;
    logic [15:0] pc_out;
    logic [7:0]  status_out, sp_out;
    logic [3:0]  src_ack;
    logic [1:0]  active_src, nest_depth;

    always #5 clk = ~clk;

    interrupt_sequencer_multi #(
        .NUM_SRC(4), .NMI_MASK(NMI_M), .EDGE_MASK(EDGE_M),
        .VEC_BASE(VBASE), .BRK_VEC(BVEC), .MAX_NEST(MAXN)
    ) dut (
        .clk(clk), .rst(rst), .halt(halt), .start(start), .is_brk(is_brk), .is_rti(is_rti),
        .src_n(src_n), .pc_in(pc_in), .status_in(status_in), .sp_in(sp_in),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .busy(busy), .done(done), .pc_out(pc_out), .status_out(status_out), .sp_out(sp_out),
        .src_ack(src_ack), .active_src(active_src), .nest_depth(nest_depth)
    );

    // Memory contents are fixed by the stimulus; writes are only logged.
    logic [7:0]  mem [0:65535];
    logic [23:0] wlog [0:4095];
    int          wr_cnt = 0;

    always @(posedge clk) begin
        mem_rdata <= mem[mem_addr];
        if (mem_we) begin
            wlog[wr_cnt % 4096] <= {mem_addr, mem_wdata};
            wr_cnt <= wr_cnt + 1;
        end
    end

    int         errors = 0;
    int         checks = 0;
    logic [3:0] m_pend = '0;
    logic [3:0] m_prev = '1;
    int         m_nest = 0;
    int         m_act = 0;
    int         last_w0 = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return 0;
    endfunction

    // One clock edge; the model tracks falling edges seen and sources taken.
    task automatic tick(input logic [3:0] take);
        logic [3:0] fall;
        fall = m_prev & ~src_n & EDGE_M;
        @(posedge clk);
        #1;
        if (rst) begin
            m_pend = '0;
            m_prev = '1;
            m_nest = 0;
            m_act  = 0;
        end else begin
            m_pend = fall | (m_pend & ~take & EDGE_M);
            m_prev = src_n;
        end
    endtask

    task automatic txn(input logic [15:0] pc, input logic [7:0] st, input logic [7:0] sp,
                       input logic brk, input logic rti, input logic hold);
        logic [3:0]  now_p, take;
        logic [15:0] vec, e_pc;
        logic [7:0]  e_st, e_sp, pushed, s1, s2, s3, m1, m2;
        logic [23:0] e_w [3];
        int          kind, idx, w0, nw;
        now_p = (m_pend & EDGE_M) | (~src_n & ~EDGE_M);
        kind = 0;
        idx  = 0;
        if (rti) kind = 3;
        else if (m_nest < MAXN && (now_p & NMI_M) != 4'd0) begin kind = 1; idx = lowest(now_p & NMI_M); end
        else if (brk) kind = 2;
        else if (m_nest < MAXN && !st[2] && (now_p & ~NMI_M) != 4'd0) begin kind = 1; idx = lowest(now_p & ~NMI_M); end
        vec    = (kind == 2) ? BVEC : VBASE + 16'(2 * idx);
        s1     = sp + 8'd1;
        s2     = sp + 8'd2;
        s3     = sp + 8'd3;
        m1     = sp - 8'd1;
        m2     = sp - 8'd2;
        pushed = (kind == 2) ? (st | 8'h30) : ((st | 8'h20) & 8'hEF);
        nw     = 0;
        case (kind)
            0: begin e_pc = pc; e_st = st; e_sp = sp; end
            3: begin
                e_pc = {mem[{8'h01, s3}], mem[{8'h01, s2}]};
                e_st = mem[{8'h01, s1}] & 8'hCF;
                e_sp = s3;
            end
            default: begin
                e_pc = {mem[vec + 16'd1], mem[vec]};
                e_st = st | 8'h04;
                e_sp = sp - 8'd3;
                nw   = 3;
            end
        endcase
        e_w[0] = {8'h01, sp, pc[15:8]};
        e_w[1] = {8'h01, m1, pc[7:0]};
        e_w[2] = {8'h01, m2, pushed};
        take = (kind == 1) ? 4'(1 << idx) : 4'd0;

        pc_in = pc; status_in = st; sp_in = sp; is_brk = brk; is_rti = rti; start = 1'b1;
        w0 = wr_cnt;
        last_w0 = w0;
        tick(take);
        start = (kind == 0) ? 1'b0 : hold;
        if (kind == 1) begin
            m_nest = (m_nest < MAXN) ? m_nest + 1 : MAXN;
            m_act  = idx;
        end else if (kind == 3) begin
            m_nest = (m_nest > 0) ? m_nest - 1 : 0;
        end
        check("src_ack", src_ack, take);
        check("active_src", active_src, m_act);
        check("nest_depth", nest_depth, m_nest);
        check("busy_start", busy, kind != 0);
        check("done_start", done, kind == 0);
        if (kind == 0) begin
            check("pc_none", pc_out, e_pc);
            check("status_none", status_out, e_st);
            check("sp_none", sp_out, e_sp);
            tick(4'd0);
            check("done_after_none", done, 0);
            check("writes_none", wr_cnt - w0, 0);
            return;
        end
        check("addr_e1", mem_addr, (kind == 3) ? {8'h01, s1} : vec);
        for (int e = 2; e <= 5; e++) begin
            if (e == 5) start = 1'b0;
            tick(4'd0);
            check("done_edge", done, e == 5);
            if (e == 2) check("addr_e2", mem_addr, (kind == 3) ? {8'h01, s2} : vec + 16'd1);
            if (e == 3) check("addr_e3", mem_addr, (kind == 3) ? {8'h01, s3} : {8'h01, sp});
        end
        check("pc_out", pc_out, e_pc);
        check("status_out", status_out, e_st);
        check("sp_out", sp_out, e_sp);
        tick(4'd0);
        check("done_fin", done, 0);
        check("busy_fin", busy, 0);
        check("we_fin", mem_we, 0);
        check("write_count", wr_cnt - w0, nw);
        for (int k = 0; k < nw; k++) check("write_data", wlog[(w0 + k) % 4096], e_w[k]);
    endtask

    task automatic drain_nest();
        for (int n = 0; n < 4 && m_nest > 0; n++) txn(16'h0, 8'h0, 8'($urandom), 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        rst = 1'b1; halt = 1'b0; start = 1'b0; is_brk = 1'b0; is_rti = 1'b0;
        src_n = '1; pc_in = '0; status_in = '0; sp_in = '0;
        tick(4'd0);
        tick(4'd0);
        check("rst_pc", pc_out, 0);
        check("rst_status", status_out, 0);
        check("rst_sp", sp_out, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_we", mem_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ack", src_ack, 0);
        check("rst_act", active_src, 0);
        check("rst_nest", nest_depth, 0);
        rst = 1'b0;
        tick(4'd0);

        // NMI on source 0 with the reference stack frame
        src_n = 4'b1110;
        tick(4'd0);
        txn(16'h8123, 8'h04, 8'hFD, 1'b0, 1'b0, 1'b0);
        check("s1_push_pch", wlog[last_w0 % 4096], 24'h01FD81);
        check("s1_push_pcl", wlog[(last_w0 + 1) % 4096], 24'h01FC23);
        check("s1_sp", sp_out, 8'hFA);
        src_n = 4'b1111;

        // Masked level source: nothing taken, request survives until unmasked
        src_n = 4'b1101;
        tick(4'd0);
        txn(16'h1000, 8'h04, 8'h90, 1'b0, 1'b0, 1'b0);
        txn(16'h1000, 8'h00, 8'h90, 1'b0, 1'b0, 1'b1);
        src_n = 4'b1111;

        // RTI across the page-1 wrap
        txn(16'h2000, 8'h00, 8'hFE, 1'b0, 1'b1, 1'b0);
        check("rti_sp", sp_out, 8'h01);
        drain_nest();

        // NMI and BRK together: NMI wins, then nothing left pending
        tick(4'd0);
        src_n = 4'b1110;
        tick(4'd0);
        txn(16'h3456, 8'h1B, 8'h40, 1'b1, 1'b0, 1'b0);
        check("nmi_b4_clear", {31'd0, wlog[(last_w0 + 2) % 4096][4]}, 0);
        src_n = 4'b1111;
        tick(4'd0);
        txn(16'h3456, 8'h00, 8'h40, 1'b0, 1'b0, 1'b0);
        check("nmi_pend_cleared", done, 0);
        drain_nest();

        // Three nested level interrupts, fourth refused, RTI unwinds one
        src_n = 4'b1011;
        tick(4'd0);
        for (int n = 0; n < 4; n++) txn(16'(16'h5000 + n), 8'h00, 8'(8'hC0 - 3 * n), 1'b0, 1'b0, 1'b0);
        check("nest_full", nest_depth, 2'd3);
        src_n = 4'b1111;
        txn(16'h0, 8'h00, 8'hB7, 1'b0, 1'b1, 1'b0);
        check("nest_after_rti", nest_depth, 2'd2);
        drain_nest();

        // Fresh fall on the taking edge keeps the request pending
        src_n = 4'b1110; tick(4'd0);
        src_n = 4'b1111; tick(4'd0);
        src_n = 4'b1110;
        txn(16'h6000, 8'h00, 8'h70, 1'b0, 1'b0, 1'b0);
        txn(16'h6001, 8'h00, 8'h70, 1'b0, 1'b0, 1'b0);
        src_n = 4'b1111;
        drain_nest();

        // Halt inside PUSH_PCL, then reset during PUSH_P
        tick(4'd0);
        src_n = 4'b1110;
        tick(4'd0);
        pc_in = 16'h4567; status_in = 8'h00; sp_in = 8'h80; is_brk = 1'b0; is_rti = 1'b0; start = 1'b1;
        tick(4'b0001);
        start = 1'b0;
        src_n = 4'b1111;
        tick(4'd0);
        tick(4'd0);
        halt = 1'b1;
        for (int h = 0; h < 3; h++) begin
            tick(4'd0);
            check("halt_addr", mem_addr, 16'h0180);
            check("halt_wdata", mem_wdata, 8'h45);
            check("halt_we", mem_we, 1);
            check("halt_pc", pc_out, 16'h4567);
            check("halt_status", status_out, 8'h04);
            check("halt_busy", busy, 1);
            check("halt_done", done, 0);
        end
        halt = 1'b0;
        tick(4'd0);
        check("resume_pc", pc_out, {mem[16'hFFF1], mem[16'hFFF0]});
        check("resume_addr", mem_addr, 16'h017F);
        check("resume_wdata", mem_wdata, 8'h67);
        rst = 1'b1;
        tick(4'd0);
        rst = 1'b0;
        check("abort_we", mem_we, 0);
        check("abort_done", done, 0);
        check("abort_busy", busy, 0);
        check("abort_pc", pc_out, 0);
        check("abort_sp", sp_out, 0);
        check("abort_nest", nest_depth, 0);
        tick(4'd0);
        check("abort_no_done", done, 0);

        // Randomised traffic
        for (int t = 0; t < 60; t++) begin
            src_n = 4'($urandom);
            tick(4'd0);
            txn(16'($urandom), 8'($urandom), 8'($urandom),
                $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
